// File: rtl/oisc8_pkg.sv
// Shared OISC8 definitions: stack full-policy type and stack defaults.
package oisc8_pkg;

   typedef enum logic {
      STK_SATURATE = 1'b0,
      STK_WRAP     = 1'b1
   } stk_mode_t;

   localparam int unsigned STK_DEFAULT_DEPTH  = 16;
   localparam int unsigned STK_DEFAULT_DWIDTH = 8;

endpackage

// File: rtl/oisc_stack_ram.sv
// Stack storage: DEPTH x DWIDTH register file, one sync write port,
// two async read ports. Contents are never reset.
module oisc_stack_ram #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned DEPTH  = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic [AW-1:0]     top_addr,
   output logic [DWIDTH-1:0] top_q,
   input  logic [AW-1:0]     peek_addr,
   output logic [DWIDTH-1:0] peek_q
);

   logic [DWIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign top_q  = mem[top_addr];
   assign peek_q = mem[peek_addr];

endmodule

// File: rtl/oisc_stack_engine.sv
// OISC8 hardware LIFO: ring storage with pointer/count/flag control,
// replace-top on push+pop, random-depth peek and sticky ovf/udf.
module oisc_stack_engine
   import oisc8_pkg::*;
#(
   parameter int unsigned DWIDTH = STK_DEFAULT_DWIDTH,
   parameter int unsigned DEPTH  = STK_DEFAULT_DEPTH,
   parameter stk_mode_t   MODE   = STK_SATURATE,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_en,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop_en,
   input  logic [AW-1:0]     peek_idx,
   input  logic              clr_flags,
   output logic [DWIDTH-1:0] top_data,
   output logic [DWIDTH-1:0] peek_data,
   output logic [CW-1:0]     count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              udf
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("oisc_stack_engine: DEPTH must be a power of two and at least 2");
   end

   logic [AW-1:0]     ptr, ptr_d;
   logic [CW-1:0]     cnt_d;
   logic [AW-1:0]     top_addr, peek_addr, wr_addr;
   logic              wr_en;
   logic              ovf_set, udf_set;
   logic [DWIDTH-1:0] top_q, peek_q;

   assign empty     = (count == CW'(0));
   assign full      = (count == CW'(DEPTH));
   assign top_addr  = ptr - AW'(1);
   assign peek_addr = ptr - AW'(1) - peek_idx;

   // Next-state decode for the {push_en, pop_en} operation
   always_comb begin
      ptr_d   = ptr;
      cnt_d   = count;
      wr_en   = 1'b0;
      wr_addr = ptr;
      ovf_set = 1'b0;
      udf_set = 1'b0;
      unique case ({push_en, pop_en})
         2'b10: begin
            if (!full) begin
               wr_en = 1'b1;
               ptr_d = ptr + AW'(1);
               cnt_d = count + CW'(1);
            end else begin
               ovf_set = 1'b1;
               if (MODE == STK_WRAP) begin
                  wr_en = 1'b1;
                  ptr_d = ptr + AW'(1);
               end
            end
         end
         2'b01: begin
            if (!empty) begin
               ptr_d = ptr - AW'(1);
               cnt_d = count - CW'(1);
            end else begin
               udf_set = 1'b1;
            end
         end
         2'b11: begin
            wr_en = 1'b1;
            if (!empty) begin
               wr_addr = top_addr;
            end else begin
               // empty stack is never full, so this is a plain push
               ptr_d = ptr + AW'(1);
               cnt_d = count + CW'(1);
            end
         end
         default: ;
      endcase
   end

   // Pointer, count and sticky flags; setting a flag wins over clearing it
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
         ovf   <= 1'b0;
         udf   <= 1'b0;
      end else begin
         ptr   <= ptr_d;
         count <= cnt_d;
         ovf   <= ovf_set | (ovf & ~clr_flags);
         udf   <= udf_set | (udf & ~clr_flags);
      end
   end

   oisc_stack_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk       (clk),
      .wr_en     (wr_en & ~rst),
      .wr_addr   (wr_addr),
      .wr_data   (push_data),
      .top_addr  (top_addr),
      .top_q     (top_q),
      .peek_addr (peek_addr),
      .peek_q    (peek_q)
   );

   assign top_data  = empty ? '0 : top_q;
   assign peek_data = (CW'(peek_idx) < count) ? peek_q : '0;

endmodule

// File: tb/tb_oisc_stack_engine.sv
// Directed bench: DEPTH=16 saturate, DEPTH=4 saturate and DEPTH=4 wrap instances.
module tb_oisc_stack_engine;
   import oisc8_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [7:0] din = '0;

   logic       a_push = 0, a_pop = 0;
   logic [3:0] a_peek = '0;
   logic [7:0] a_top, a_pk;
   logic [4:0] a_cnt;
   logic       a_empty, a_full, a_ovf, a_udf;

   logic       b_push = 0, b_pop = 0;
   logic [1:0] b_peek = '0;
   logic [7:0] b_top, b_pk;
   logic [2:0] b_cnt;
   logic       b_empty, b_full, b_ovf, b_udf;

   logic       c_push = 0, c_pop = 0;
   logic [1:0] c_peek = '0;
   logic [7:0] c_top, c_pk;
   logic [2:0] c_cnt;
   logic       c_empty, c_full, c_ovf, c_udf;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   oisc_stack_engine #(.DWIDTH(8), .DEPTH(16), .MODE(STK_SATURATE)) u_a (
      .clk(clk), .rst(rst), .push_en(a_push), .push_data(din), .pop_en(a_pop),
      .peek_idx(a_peek), .clr_flags(clr), .top_data(a_top), .peek_data(a_pk),
      .count(a_cnt), .empty(a_empty), .full(a_full), .ovf(a_ovf), .udf(a_udf));

   oisc_stack_engine #(.DWIDTH(8), .DEPTH(4), .MODE(STK_SATURATE)) u_b (
      .clk(clk), .rst(rst), .push_en(b_push), .push_data(din), .pop_en(b_pop),
      .peek_idx(b_peek), .clr_flags(clr), .top_data(b_top), .peek_data(b_pk),
      .count(b_cnt), .empty(b_empty), .full(b_full), .ovf(b_ovf), .udf(b_udf));

   oisc_stack_engine #(.DWIDTH(8), .DEPTH(4), .MODE(STK_WRAP)) u_c (
      .clk(clk), .rst(rst), .push_en(c_push), .push_data(din), .pop_en(c_pop),
      .peek_idx(c_peek), .clr_flags(clr), .top_data(c_top), .peek_data(c_pk),
      .count(c_cnt), .empty(c_empty), .full(c_full), .ovf(c_ovf), .udf(c_udf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clocked operation on instance inst (0=a, 1=b, 2=c)
   task automatic op(input int inst, input logic pu, input logic po, input logic [7:0] d);
      din = d;
      case (inst)
         0: begin a_push = pu; a_pop = po; end
         1: begin b_push = pu; b_pop = po; end
         default: begin c_push = pu; c_pop = po; end
      endcase
      @(posedge clk); #1;
      a_push = 0; a_pop = 0; b_push = 0; b_pop = 0; c_push = 0; c_pop = 0;
      clr = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // reset state
      chk("rst_cnt", 32'(a_cnt), 0);
      chk("rst_empty", 32'(a_empty), 1);
      chk("rst_full", 32'(a_full), 0);
      chk("rst_top", 32'(a_top), 0);
      chk("rst_peek", 32'(a_pk), 0);
      chk("rst_ovf", 32'(a_ovf), 0);
      chk("rst_udf", 32'(a_udf), 0);

      // push 11,22,33 and peek
      op(0, 1, 0, 8'h11);
      chk("push1_top", 32'(a_top), 32'h11);
      op(0, 1, 0, 8'h22);
      op(0, 1, 0, 8'h33);
      chk("push3_top", 32'(a_top), 32'h33);
      chk("push3_cnt", 32'(a_cnt), 3);
      chk("push3_empty", 32'(a_empty), 0);
      a_peek = 4'd2; #1;
      chk("peek2", 32'(a_pk), 32'h11);
      a_peek = 4'd1; #1;
      chk("peek1", 32'(a_pk), 32'h22);
      a_peek = 4'd3; #1;
      chk("peek3_invalid", 32'(a_pk), 0);
      a_peek = 4'd0; #1;
      chk("peek0", 32'(a_pk), 32'h33);

      // pops: value observed before the edge
      chk("pop1_val", 32'(a_top), 32'h33); op(0, 0, 1, 8'h00);
      chk("pop2_val", 32'(a_top), 32'h22); op(0, 0, 1, 8'h00);
      chk("pop3_val", 32'(a_top), 32'h11); op(0, 0, 1, 8'h00);
      chk("pop3_udf", 32'(a_udf), 0);
      chk("pop3_empty", 32'(a_empty), 1);
      op(0, 0, 1, 8'h00);
      chk("pop4_udf", 32'(a_udf), 1);
      chk("pop4_cnt", 32'(a_cnt), 0);
      chk("pop4_top", 32'(a_top), 0);
      clr = 1; op(0, 0, 0, 8'h00);
      chk("clr_udf", 32'(a_udf), 0);

      // replace top
      op(0, 1, 0, 8'hA0);
      op(0, 1, 0, 8'hB0);
      op(0, 1, 1, 8'hC5);
      chk("repl_top", 32'(a_top), 32'hC5);
      chk("repl_cnt", 32'(a_cnt), 2);
      a_peek = 4'd1; #1;
      chk("repl_peek1", 32'(a_pk), 32'hA0);
      a_peek = 4'd0;
      op(0, 0, 1, 8'h00);
      op(0, 0, 1, 8'h00);
      chk("drain_cnt", 32'(a_cnt), 0);
      op(0, 1, 1, 8'h7E);
      chk("repl_empty_cnt", 32'(a_cnt), 1);
      chk("repl_empty_top", 32'(a_top), 32'h7E);
      chk("repl_empty_udf", 32'(a_udf), 0);

      // DEPTH=4 saturate
      for (int i = 1; i <= 4; i++) op(1, 1, 0, 8'(i));
      chk("sat_full", 32'(b_full), 1);
      chk("sat_ovf_pre", 32'(b_ovf), 0);
      op(1, 1, 0, 8'h05);
      chk("sat_ovf", 32'(b_ovf), 1);
      chk("sat_top", 32'(b_top), 4);
      chk("sat_cnt", 32'(b_cnt), 4);
      b_peek = 2'd3; #1;
      chk("sat_peek3", 32'(b_pk), 1);
      clr = 1; op(1, 1, 0, 8'h06);
      chk("clr_vs_set_ovf", 32'(b_ovf), 1);
      chk("clr_vs_set_top", 32'(b_top), 4);
      clr = 1; op(1, 0, 0, 8'h00);
      chk("clr_ovf", 32'(b_ovf), 0);
      op(1, 1, 1, 8'h09);
      chk("repl_full_top", 32'(b_top), 9);
      chk("repl_full_ovf", 32'(b_ovf), 0);
      chk("repl_full_cnt", 32'(b_cnt), 4);

      // reset wins over push
      rst = 1; din = 8'hEE; b_push = 1;
      @(posedge clk); #1;
      rst = 0; b_push = 0;
      chk("rst_push_cnt", 32'(b_cnt), 0);
      chk("rst_push_top", 32'(b_top), 0);
      chk("rst_push_empty", 32'(b_empty), 1);

      // DEPTH=4 wrap
      for (int i = 1; i <= 6; i++) op(2, 1, 0, 8'(i));
      chk("wrap_ovf", 32'(c_ovf), 1);
      chk("wrap_cnt", 32'(c_cnt), 4);
      chk("wrap_full", 32'(c_full), 1);
      c_peek = 2'd3; #1;
      chk("wrap_peek3", 32'(c_pk), 3);
      chk("wrap_pop1", 32'(c_top), 6); op(2, 0, 1, 8'h00);
      chk("wrap_pop2", 32'(c_top), 5); op(2, 0, 1, 8'h00);
      chk("wrap_pop3", 32'(c_top), 4); op(2, 0, 1, 8'h00);
      chk("wrap_pop4", 32'(c_top), 3); op(2, 0, 1, 8'h00);
      chk("wrap_udf_pre", 32'(c_udf), 0);
      op(2, 0, 1, 8'h00);
      chk("wrap_udf", 32'(c_udf), 1);
      chk("wrap_cnt0", 32'(c_cnt), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oisc_stack_engine.md
Name: oisc_stack_engine

Overview:
- Parametrised hardware LIFO stack for the OISC8 datapath.
- Replaces the RAM-backed single-entry-cache stack with dedicated on-block storage.
- Configurable width, depth and full-stack policy (saturate or wrap).
- Adds simultaneous push+pop (replace top), random-depth peek, an occupancy count and sticky overflow/underflow flags.
- Sits behind the bus port decoder; the port logic drives push_en/pop_en for one cycle per bus access.

Parameters:
- DWIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, at least 2 (elaboration-time assertion).
- MODE, STK_SATURATE, full-stack policy: STK_SATURATE drops the push; STK_WRAP overwrites the oldest entry.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- push_en  in  1  push request, one word per cycle.
- push_data  in  DWIDTH  word to push.
- pop_en  in  1  pop request.
- peek_idx  in  $clog2(DEPTH)  entry to read; 0 = top.
- clr_flags  in  1  clears ovf/udf.
- top_data  out  DWIDTH  current top of stack; 0 when empty.
- peek_data  out  DWIDTH  entry at peek_idx; 0 when peek_idx >= count.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky overflow flag.
- udf  out  1  sticky underflow flag.

Behaviour:
- Reset (rst high at clock edge): ptr=0, count=0, ovf=0, udf=0. Memory contents are not cleared. Outputs after reset: top_data=0, peek_data=0, empty=1, full=0.
- Reset takes priority over every request in the same cycle.
- Storage is a ring of DEPTH words. ptr is the next free slot, mod DEPTH. Top entry is mem[ptr-1].
- Reads (top_data, peek_data) are combinational from registered state. A push at edge N is visible on top_data immediately after edge N (zero-cycle read latency, one-cycle write-to-read).
- Peek address is mem[(ptr-1-peek_idx) mod DEPTH].
- Operation per cycle is selected by {push_en, pop_en}:
  - 00: hold.
  - 10, not full: mem[ptr]<=push_data; ptr++; count++.
  - 10, full, STK_SATURATE: no state change; ovf<=1.
  - 10, full, STK_WRAP: mem[ptr]<=push_data; ptr++; count stays DEPTH (oldest entry lost); ovf<=1.
  - 01, not empty: ptr--; count--. Popped value is top_data before the edge; the consumer samples it in the same cycle.
  - 01, empty: no state change; udf<=1.
  - 11, not empty: mem[ptr-1]<=push_data (replace top); ptr and count unchanged; no flags, even when full.
  - 11, empty: behaves as a plain push; no udf.
- clr_flags clears ovf/udf. If a new overflow/underflow occurs in the same cycle, setting wins over clear.
- Pointer arithmetic is unsigned and wraps naturally mod DEPTH. count saturates at DEPTH and never goes below 0.

Decomposition:
- Shared package oisc8_pkg gains typedef enum logic {STK_SATURATE, STK_WRAP} stk_mode_t.
- Also add a localparam for the default stack depth there.
- One sub-module: oisc_stack_ram.
  - DEPTH x DWIDTH register file.
  - One synchronous write port.
  - Two asynchronous read ports (top, peek).
  - No reset on contents.
- Pointer, count and flag control stay in oisc_stack_engine.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> top_data=0x33, count=3, peek_idx=2 gives 0x11, peek_idx=3 gives 0.
- Pop 4 times from {0x11,0x22,0x33} -> pops return 0x33, 0x22, 0x11; 4th pop sets udf=1, count stays 0, top_data=0.
- DEPTH=4, STK_SATURATE: push 1..5 -> full=1 after 4 pushes, ovf=1 after 5th, top_data=4, count=4.
- DEPTH=4, STK_WRAP: push 1..6 -> ovf=1, count=4, pops return 6, 5, 4, 3, then udf on the 5th pop.
- Stack {0xA0,0xB0}, push_en+pop_en with 0xC5 -> top_data=0xC5, count=2, peek_idx=1 gives 0xA0. Repeat on empty stack with 0x7E -> count=1, top_data=0x7E, udf=0.
- Set ovf, then assert clr_flags together with an overflowing push -> ovf stays 1. clr_flags alone next cycle -> ovf=0. Assert rst together with push -> count=0, push ignored.
